seg_digit_scanner: RTL and testbench



---
 rtl/seg_pkg.sv | 21 ++
 rtl/seg_refresh_timer.sv | 49 ++++
 rtl/seg_digit_scanner.sv | 140 ++++++++++++++
 tb/tb_seg_digit_scanner.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: digit code widths, the blank code and the
// BCD nibble to decoder-code mapping reused by every display block.
package seg_pkg;

  localparam int unsigned BCD_W   = 4;
  localparam int unsigned DIGIT_W = 5;

  localparam logic [DIGIT_W-1:0] BLANK_CODE = 5'h1F;

  // One display slot as presented to the decoder; dp_n is active-low.
  typedef struct packed {
    logic [DIGIT_W-1:0] code;
    logic               dp_n;
  } seg_slot_t;

  // Decimal nibbles pass through; 10..15 have no glyph and are blanked.
  function automatic logic [DIGIT_W-1:0] bcd_to_code(input logic [BCD_W-1:0] nib);
    return (nib <= 4'd9) ? {1'b0, nib} : BLANK_CODE;
  endfunction

endpackage

// File: rtl/seg_refresh_timer.sv
// Prescaler and slot index counter for the digit scanner. All outputs are
// look-ahead: they describe the cycle that follows the current clock edge.
module seg_refresh_timer #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned GUARD_CYCLES = 500,
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic             clkIn,
  input  logic             rstIn,
  output logic [IDX_W-1:0] idx_next_c,
  output logic             slot_start_c,
  output logic             guard_active_c,
  output logic             frame_wrap_c
);

  localparam int unsigned PRE_W = $clog2(REFRESH_DIV);

  logic [PRE_W-1:0] pre;
  logic [PRE_W-1:0] pre_next;
  logic [IDX_W-1:0] idx;
  logic             wrap;

  // Next prescaler/index; the index only moves when the prescaler wraps.
  always_comb begin
    wrap       = (pre == PRE_W'(REFRESH_DIV - 1));
    pre_next   = pre + 1'b1;
    idx_next_c = idx;
    if (wrap) begin
      pre_next   = '0;
      idx_next_c = (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
    end
  end

  assign slot_start_c   = wrap;
  assign frame_wrap_c   = wrap && (idx == IDX_W'(NUM_DIGITS - 1));
  assign guard_active_c = (32'(pre_next) < GUARD_CYCLES);

  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      pre <= '0;
      idx <= '0;
    end else begin
      pre <= pre_next;
      idx <= idx_next_c;
    end
  end

endmodule

// File: rtl/seg_digit_scanner.sv
// Time-multiplexes a frame of BCD digits onto one seven-segment decoder with
// tear-free frame loading, anti-ghosting guard time and leading-zero blanking.
module seg_digit_scanner
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned GUARD_CYCLES = 500
) (
  input  logic                        clkIn,
  input  logic                        rstIn,
  input  logic [BCD_W*NUM_DIGITS-1:0] valueIn,
  input  logic [NUM_DIGITS-1:0]       dpIn,
  input  logic                        loadIn,
  input  logic                        blankLeadIn,
  output logic [DIGIT_W-1:0]          digitOut,
  output logic                        dpOut,
  output logic [NUM_DIGITS-1:0]       anodeOut,
  output logic                        frameOut
);

  localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned FRAME_W = BCD_W * NUM_DIGITS;

  logic [IDX_W-1:0]      idx_next_c;
  logic                  slot_start_c;
  logic                  guard_active_c;
  logic                  frame_wrap_c;

  logic [FRAME_W-1:0]    hold_val;
  logic [NUM_DIGITS-1:0] hold_dp;
  logic                  pending;
  logic                  pending_next;
  logic [FRAME_W-1:0]    shadow_val;
  logic [FRAME_W-1:0]    shadow_val_next;
  logic [NUM_DIGITS-1:0] shadow_dp;
  logic [NUM_DIGITS-1:0] shadow_dp_next;

  logic [BCD_W-1:0]      nib;
  logic                  dp_sel;
  logic                  lead_zero;
  seg_slot_t             slot_next;
  logic [NUM_DIGITS-1:0] anode_next;

  seg_refresh_timer #(
    .NUM_DIGITS  (NUM_DIGITS),
    .REFRESH_DIV (REFRESH_DIV),
    .GUARD_CYCLES(GUARD_CYCLES)
  ) u_timer (
    .clkIn         (clkIn),
    .rstIn         (rstIn),
    .idx_next_c    (idx_next_c),
    .slot_start_c  (slot_start_c),
    .guard_active_c(guard_active_c),
    .frame_wrap_c  (frame_wrap_c)
  );

  // Shadow only changes at the frame boundary; a load on that exact cycle wins.
  always_comb begin
    shadow_val_next = shadow_val;
    shadow_dp_next  = shadow_dp;
    pending_next    = pending;
    if (loadIn) begin
      pending_next = 1'b1;
    end
    if (frame_wrap_c) begin
      pending_next = 1'b0;
      if (loadIn) begin
        shadow_val_next = valueIn;
        shadow_dp_next  = dpIn;
      end else if (pending) begin
        shadow_val_next = hold_val;
        shadow_dp_next  = hold_dp;
      end
    end
  end

  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      hold_val <= '0;
      hold_dp  <= '0;
    end else if (loadIn) begin
      hold_val <= valueIn;
      hold_dp  <= dpIn;
    end
  end

  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      shadow_val <= '0;
      shadow_dp  <= '0;
      pending    <= 1'b0;
    end else begin
      shadow_val <= shadow_val_next;
      shadow_dp  <= shadow_dp_next;
      pending    <= pending_next;
    end
  end

  // Digit for the upcoming slot: blanked when it and every higher nibble are zero.
  always_comb begin
    nib       = '0;
    dp_sel    = 1'b0;
    lead_zero = 1'b1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (32'(idx_next_c) == i) begin
        nib    = shadow_val_next[i*BCD_W +: BCD_W];
        dp_sel = shadow_dp_next[i];
      end
      if ((i >= 32'(idx_next_c)) && (shadow_val_next[i*BCD_W +: BCD_W] != '0)) begin
        lead_zero = 1'b0;
      end
    end
    slot_next.code = (blankLeadIn && (idx_next_c != '0) && lead_zero) ? BLANK_CODE
                                                                       : bcd_to_code(nib);
    slot_next.dp_n = ~dp_sel;
    anode_next     = '1;
    if (!guard_active_c) begin
      anode_next[idx_next_c] = 1'b0;
    end
  end

  // Digit and dp latch at slot start so they hold through the guard period.
  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      anodeOut <= '1;
      digitOut <= BLANK_CODE;
      dpOut    <= 1'b1;
      frameOut <= 1'b0;
    end else begin
      anodeOut <= anode_next;
      frameOut <= frame_wrap_c;
      if (slot_start_c) begin
        digitOut <= slot_next.code;
        dpOut    <= slot_next.dp_n;
      end
    end
  end

endmodule

// File: tb/tb_seg_digit_scanner.sv
// Self-checking bench for seg_digit_scanner: cycle-count based reference model,
// directed frame scenarios with literal expectations, then randomized traffic.
module tb_seg_digit_scanner;

  localparam int N = 4;
  localparam int R = 8;
  localparam int G = 2;

  logic        clkIn = 1'b0;
  logic        rstIn = 1'b1;
  logic [15:0] valueIn = '0;
  logic [3:0]  dpIn = '0;
  logic        loadIn = 1'b0;
  logic        blankLeadIn = 1'b0;
  logic [4:0]  digitOut;
  logic        dpOut;
  logic [3:0]  anodeOut;
  logic        frameOut;

  always #5 clkIn = ~clkIn;

  seg_digit_scanner #(
    .NUM_DIGITS  (N),
    .REFRESH_DIV (R),
    .GUARD_CYCLES(G)
  ) dut (
    .clkIn      (clkIn),
    .rstIn      (rstIn),
    .valueIn    (valueIn),
    .dpIn       (dpIn),
    .loadIn     (loadIn),
    .blankLeadIn(blankLeadIn),
    .digitOut   (digitOut),
    .dpOut      (dpOut),
    .anodeOut   (anodeOut),
    .frameOut   (frameOut)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: position in the scan follows from cycles since reset.
  bit          seen_reset = 1'b0;
  bit          m_rst_out  = 1'b1;
  int          t = 0;
  logic [15:0] m_shadow = '0;
  logic [3:0]  m_shadow_dp = '0;
  bit          m_pend = 1'b0;
  logic [15:0] m_pend_val = '0;
  logic [3:0]  m_pend_dp = '0;
  logic [4:0]  m_digit = 5'h1F;
  bit          m_dp = 1'b1;

  always @(posedge clkIn) begin
    int          slot;
    logic [15:0] upper;
    if (rstIn) begin
      seen_reset  = 1'b1;
      m_rst_out   = 1'b1;
      t           = 0;
      m_shadow    = '0;
      m_shadow_dp = '0;
      m_pend      = 1'b0;
      m_digit     = 5'h1F;
      m_dp        = 1'b1;
    end else if (seen_reset) begin
      t++;
      m_rst_out = 1'b0;
      if (loadIn) begin
        m_pend     = 1'b1;
        m_pend_val = valueIn;
        m_pend_dp  = dpIn;
      end
      if ((t % (R * N)) == 0 && m_pend) begin
        m_shadow    = m_pend_val;
        m_shadow_dp = m_pend_dp;
        m_pend      = 1'b0;
      end
      if ((t % R) == 0) begin
        slot  = (t / R) % N;
        upper = m_shadow >> (4 * slot);
        if (blankLeadIn && slot > 0 && upper == 16'h0) m_digit = 5'h1F;
        else if (upper[3:0] > 4'd9) m_digit = 5'h1F;
        else m_digit = {1'b0, upper[3:0]};
        m_dp = ~m_shadow_dp[slot];
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clkIn) begin
    logic [3:0] exp_anode;
    bit         exp_frame;
    int         p;
    if (seen_reset) begin
      if (m_rst_out) begin
        exp_anode = 4'hF;
        exp_frame = 1'b0;
      end else begin
        p         = t % R;
        exp_anode = (p < G) ? 4'hF : ~(4'b0001 << ((t / R) % N));
        exp_frame = ((t % (R * N)) == 0);
      end
      chk("model_anode", anodeOut, exp_anode);
      chk("model_digit", digitOut, m_digit);
      chk("model_dp", dpOut, m_dp);
      chk("model_frame", frameOut, exp_frame);
    end
  end

  task automatic wait_frame(output int n);
    n = 0;
    loadIn = 1'b0;
    do begin
      @(negedge clkIn);
      n++;
    end while (!frameOut && n < 200);
    chk("frame_seen", frameOut, 1'b1);
  endtask

  task automatic load(input logic [15:0] v, input logic [3:0] d);
    valueIn = v;
    dpIn    = d;
    loadIn  = 1'b1;
    @(negedge clkIn);
    loadIn  = 1'b0;
  endtask

  // Walk one frame from its first cycle; ed packs slot digits {s3,s2,s1,s0}.
  task automatic run_frame(input logic [19:0] ed, input logic [3:0] dp_lit,
                           input int la, input logic [15:0] va,
                           input int lb, input logic [15:0] vb);
    int         low;
    int         k;
    logic [3:0] sel;
    chk("frame_start", frameOut, 1'b1);
    for (int s = 0; s < N; s++) begin
      low = 0;
      sel = ~(4'b0001 << s);
      for (int c = 0; c < R; c++) begin
        k       = s * R + c;
        loadIn  = (k == la) || (k == lb);
        valueIn = (k == lb) ? vb : va;
        dpIn    = 4'h0;
        chk($sformatf("slot%0d_digit", s), digitOut, ed[s*5 +: 5]);
        chk($sformatf("slot%0d_dp", s), dpOut, dp_lit[s] ? 1'b0 : 1'b1);
        if (anodeOut == sel) low++;
        @(negedge clkIn);
      end
      chk($sformatf("slot%0d_anode_low", s), low, R - G);
    end
  endtask

  initial begin
    int n;
    rstIn = 1'b1;
    repeat (3) @(negedge clkIn);
    rstIn = 1'b0;
    chk("rst_anode", anodeOut, 4'hF);
    chk("rst_digit", digitOut, 5'h1F);
    chk("rst_dp", dpOut, 1'b1);
    chk("rst_frame", frameOut, 1'b0);
    @(negedge clkIn);
    chk("guard_anode", anodeOut, 4'hF);
    @(negedge clkIn);
    chk("first_anode_low", anodeOut, 4'hE);
    wait_frame(n);
    chk("first_frame_gap", n, 30);
    wait_frame(n);
    chk("frame_period", n, 32);

    load(16'h1234, 4'b0010);
    wait_frame(n);
    run_frame({5'h01, 5'h02, 5'h03, 5'h04}, 4'b0010, -1, 16'h0, -1, 16'h0);

    blankLeadIn = 1'b1;
    load(16'h0050, 4'b0000);
    wait_frame(n);
    run_frame({5'h1F, 5'h1F, 5'h05, 5'h00}, 4'b0000, -1, 16'h0, -1, 16'h0);
    load(16'h0000, 4'b0000);
    wait_frame(n);
    run_frame({5'h1F, 5'h1F, 5'h1F, 5'h00}, 4'b0000, 1, 16'h1111, 3, 16'h2222);
    run_frame({5'h02, 5'h02, 5'h02, 5'h02}, 4'b0000, 31, 16'h3333, -1, 16'h0);
    run_frame({5'h03, 5'h03, 5'h03, 5'h03}, 4'b0000, -1, 16'h0, -1, 16'h0);

    blankLeadIn = 1'b0;
    load(16'hFA90, 4'b0000);
    wait_frame(n);
    run_frame({5'h1F, 5'h1F, 5'h09, 5'h00}, 4'b0000, -1, 16'h0, -1, 16'h0);

    load(16'h8888, 4'b1111);
    repeat (19) @(negedge clkIn);
    rstIn = 1'b1;
    @(negedge clkIn);
    rstIn = 1'b0;
    chk("midrst_anode", anodeOut, 4'hF);
    chk("midrst_digit", digitOut, 5'h1F);
    chk("midrst_dp", dpOut, 1'b1);
    wait_frame(n);
    chk("midrst_frame_gap", n, 32);
    run_frame({5'h00, 5'h00, 5'h00, 5'h00}, 4'b0000, -1, 16'h0, -1, 16'h0);

    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(3, 0))
        0: valueIn = 16'($urandom);
        1: valueIn = 16'($urandom) & 16'h00FF;
        2: valueIn = 16'($urandom) & 16'h000F;
        default: valueIn = 16'h0;
      endcase
      dpIn   = 4'($urandom);
      loadIn = ($urandom_range(7, 0) == 0);
      if ($urandom_range(63, 0) == 0) blankLeadIn = ~blankLeadIn;
      rstIn  = ($urandom_range(699, 0) == 0);
      @(negedge clkIn);
    end
    rstIn  = 1'b0;
    loadIn = 1'b0;
    @(negedge clkIn);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
